adc_avg_decim: RTL

Downstream consumer of the adc045 reader. Takes the 24-bit signed sample stream (single-cycle `ready_sample` strobe plus `adc045_data`) and boxcar-averages each block of 2^LOG2_N consecutive samples. Emits one decimated 24-bit signed result per block over a valid/ready handshake toward the capture/transfer logic. Flags results lost to back-pressure with a sticky bit.

---
 rtl/adc_avg_decim.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/adc_avg_decim.sv
// adc_avg_decim: boxcar average + decimate of the adc045 sample stream.
// Sums 2^LOG2_N strobed samples and emits their floored mean over valid/ready.
//
// Ports:
//   clk, rst_l         clock, async active-low reset
//   enable             1 = accumulate, 0 = discard partial block
//   ready_sample       one-cycle sample strobe
//   adc045_data        signed sample (DATA_W)
//   out_valid/ready    result handshake
//   out_data           signed averaged result (DATA_W)
//   overrun            sticky: unaccepted result overwritten
//   clr_overrun        synchronous clear of overrun (set wins)
//   blk_cnt            samples accumulated in current block
//   out_min/out_max    block min/max raw sample (only with ADC_AVG_MINMAX_EN)
//
// Optional feature macro: ADC_AVG_MINMAX_EN

module adc_avg_decim #(
  parameter  int DATA_W = 24,
  parameter  int LOG2_N = 2,
  localparam int ACC_W  = DATA_W + LOG2_N,
  localparam int CNT_W  = (LOG2_N > 0) ? LOG2_N : 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              enable,
  input  logic              ready_sample,
  input  logic [DATA_W-1:0] adc045_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              overrun,
  input  logic              clr_overrun,
`ifdef ADC_AVG_MINMAX_EN
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
`endif
  output logic [CNT_W-1:0]  blk_cnt
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'((1 << LOG2_N) - 1);

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic                     vld_q, vld_d;
  logic        [DATA_W-1:0] data_q, data_d;
  logic                     ovr_q, ovr_d;

  logic signed [ACC_W-1:0]  smp;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  shf;
  logic        [DATA_W-1:0] avg;
  logic                     take;
  logic                     last;
  logic                     done;
  logic                     hs;

  // Sign-extend; replication count is always >= 1.
  assign smp = {{(ACC_W-DATA_W+1){adc045_data[DATA_W-1]}},
                adc045_data[DATA_W-2:0]};

  assign sum  = acc_q + smp;
  // Arithmetic shift floors toward -inf; the mean always fits DATA_W.
  assign shf  = sum >>> LOG2_N;
  assign avg  = shf[DATA_W-1:0];

  assign take = enable & ready_sample;
  assign last = (cnt_q == LAST);
  assign done = take & last;
  assign hs   = vld_q & out_ready;

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    data_d = data_q;
    ovr_d  = ovr_q;

    if (!enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (take) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // A completing block always (re)loads; a handshake alone drains.
    if (done) begin
      vld_d  = 1'b1;
      data_d = avg;
    end else if (hs) begin
      vld_d  = 1'b0;
    end

    if (done && vld_q && !out_ready) begin
      ovr_d = 1'b1;
    end else if (clr_overrun) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      data_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      data_q <= data_d;
      ovr_q  <= ovr_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign overrun   = ovr_q;
  assign blk_cnt   = cnt_q;

`ifdef ADC_AVG_MINMAX_EN
  logic signed [DATA_W-1:0] s_raw;
  logic signed [DATA_W-1:0] bmin_q, bmin_d;
  logic signed [DATA_W-1:0] bmax_q, bmax_d;
  logic signed [DATA_W-1:0] nmin, nmax;
  logic        [DATA_W-1:0] omin_q, omin_d;
  logic        [DATA_W-1:0] omax_q, omax_d;
  logic                     first;

  assign s_raw = adc045_data;
  // The first sample of a block seeds the running extremes.
  assign first = (cnt_q == '0);
  assign nmin  = (first || (s_raw < bmin_q)) ? s_raw : bmin_q;
  assign nmax  = (first || (s_raw > bmax_q)) ? s_raw : bmax_q;

  always_comb begin
    bmin_d = bmin_q;
    bmax_d = bmax_q;
    omin_d = omin_q;
    omax_d = omax_q;
    if (take && !last) begin
      bmin_d = nmin;
      bmax_d = nmax;
    end
    if (done) begin
      omin_d = nmin;
      omax_d = nmax;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      bmin_q <= '0;
      bmax_q <= '0;
      omin_q <= '0;
      omax_q <= '0;
    end else begin
      bmin_q <= bmin_d;
      bmax_q <= bmax_d;
      omin_q <= omin_d;
      omax_q <= omax_d;
    end
  end

  assign out_min = omin_q;
  assign out_max = omax_q;
`endif

endmodule
